// File: rtl/ring_buffer_arbiter.sv
// Round-robin arbiter granting two producers and one consumer access to an
// external ring buffer, with occupancy tracking and a sticky consistency error.
module ring_buffer_arbiter #(
    parameter int REG_WIDTH = 8,
    parameter int PTR_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 w0_req,
    input  logic                 w1_req,
    input  logic [REG_WIDTH-1:0] w0_data,
    input  logic [REG_WIDTH-1:0] w1_data,
    output logic                 w0_gnt,
    output logic                 w1_gnt,
    input  logic                 r_req,
    output logic                 r_gnt,
    output logic                 r_valid,
    output logic [REG_WIDTH-1:0] r_data,
    output logic [1:0]           mode,
    output logic [REG_WIDTH-1:0] WData,
    input  logic [REG_WIDTH-1:0] RData,
    input  logic                 isEmpty,
    input  logic                 isFull,
    output logic [PTR_SIZE:0]    count,
    output logic                 err
);

    localparam int                DEPTH     = 2 ** PTR_SIZE;
    localparam logic [PTR_SIZE:0] DEPTH_CNT = (PTR_SIZE + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SLOT_W0 = 2'd0,
        SLOT_W1 = 2'd1,
        SLOT_R  = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10
    } mode_t;

    slot_t                ptr;
    slot_t                next_ptr;
    mode_t                mode_q;
    logic [REG_WIDTH-1:0] wdata_q;
    logic [PTR_SIZE:0]    count_q;
    logic                 r_valid_q;
    logic                 err_q;
    logic [2:0]           elig;
    logic [2:0]           gnt;

    function automatic slot_t next_slot(input slot_t s);
        unique case (s)
            SLOT_W0: return SLOT_W1;
            SLOT_W1: return SLOT_R;
            default: return SLOT_W0;
        endcase
    endfunction

    // Eligibility comes from the tracked count only; the buffer flags are
    // used solely for cross-checking. Grants are held low during reset.
    always_comb begin
        elig[SLOT_W0] = reset_n && w0_req && (count_q < DEPTH_CNT);
        elig[SLOT_W1] = reset_n && w1_req && (count_q < DEPTH_CNT);
        elig[SLOT_R]  = reset_n && r_req  && (count_q != '0);
    end

    always_comb begin
        slot_t cand;
        logic  found;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        gnt      = '0;
        next_ptr = ptr;
        cand     = ptr;
        found    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && elig[cand]) begin
                gnt[cand] = 1'b1;
                next_ptr  = next_slot(cand);
                found     = 1'b1;
            end
            cand = next_slot(cand);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= SLOT_W0;
            mode_q    <= MODE_IDLE;
            wdata_q   <= '0;
            count_q   <= '0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            ptr       <= next_ptr;
            r_valid_q <= (mode_q == MODE_READ);
            err_q     <= err_q
                       || ((mode_q == MODE_WRITE) && isFull)
                       || ((mode_q == MODE_READ)  && isEmpty);
            if (gnt[SLOT_W0]) begin
                mode_q  <= MODE_WRITE;
                wdata_q <= w0_data;
                count_q <= count_q + 1'b1;
            end else if (gnt[SLOT_W1]) begin
                mode_q  <= MODE_WRITE;
                wdata_q <= w1_data;
                count_q <= count_q + 1'b1;
            end else if (gnt[SLOT_R]) begin
                mode_q  <= MODE_READ;
                count_q <= count_q - 1'b1;
            end else begin
                mode_q  <= MODE_IDLE;
            end
        end
    end

    // The buffer presents read data in the cycle r_valid is high.
    assign r_data  = RData;
    assign w0_gnt  = gnt[SLOT_W0];
    assign w1_gnt  = gnt[SLOT_W1];
    assign r_gnt   = gnt[SLOT_R];
    assign mode    = mode_q;
    assign WData   = wdata_q;
    assign count   = count_q;
    assign r_valid = r_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ring_buffer_arbiter.sv
// Directed bench for ring_buffer_arbiter with a small FIFO model standing in
// for the ring buffer; isFull can be forced to provoke the error flag.
module tb_ring_buffer_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       w0_req, w1_req, r_req;
    logic [7:0] w0_data, w1_data;
    logic       w0_gnt, w1_gnt, r_gnt, r_valid;
    logic [7:0] r_data;
    logic [1:0] mode;
    logic [7:0] WData;
    logic [7:0] RData;
    logic       isEmpty, isFull;
    logic [3:0] count;
    logic       err;
    logic       force_full;

    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    logic [3:0] occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_buffer_arbiter #(.REG_WIDTH(8), .PTR_SIZE(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .w0_req(w0_req), .w1_req(w1_req),
        .w0_data(w0_data), .w1_data(w1_data),
        .w0_gnt(w0_gnt), .w1_gnt(w1_gnt),
        .r_req(r_req), .r_gnt(r_gnt),
        .r_valid(r_valid), .r_data(r_data),
        .mode(mode), .WData(WData), .RData(RData),
        .isEmpty(isEmpty), .isFull(isFull),
        .count(count), .err(err)
    );

    // Ring buffer stand-in: executes the registered command, read data
    // appears the cycle after a read command.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            occ   <= '0;
            RData <= '0;
        end else if (mode == 2'b10) begin
            mem[wp] <= WData;
            wp      <= wp + 3'd1;
            occ     <= occ + 4'd1;
        end else if (mode == 2'b01) begin
            RData <= mem[rp];
            rp    <= rp + 3'd1;
            occ   <= occ - 4'd1;
        end
    end

    assign isEmpty = (occ == 4'd0);
    assign isFull  = (occ == 4'd8) || force_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_g [6];
        logic [3:0] exp_c [6];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_c = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd7, 4'd6};

        reset_n    = 1'b0;
        w0_req     = 1'b1;
        w1_req     = 1'b0;
        r_req      = 1'b0;
        w0_data    = '0;
        w1_data    = '0;
        force_full = 1'b0;

        // Reset state, with a request pending that must not be granted.
        tick();
        check("rst_w0_gnt", w0_gnt, 0);
        check("rst_mode", mode, 0);
        check("rst_wdata", WData, 0);
        check("rst_count", count, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_err", err, 0);
        tick();

        // Four consecutive W0 writes, granted from the first edge after reset.
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            w0_data = 8'(i);
            #1;
            check("w0_burst_gnt", w0_gnt, 1);
            if (i > 1) begin
                check("w0_burst_mode", mode, 2'b10);
                check("w0_burst_wdata", WData, i - 1);
                check("w0_burst_count", count, i - 1);
            end
            tick();
        end
        w0_req = 1'b0;
        #1;
        check("w0_end_gnt", w0_gnt, 0);
        check("w0_end_mode", mode, 2'b10);
        check("w0_end_wdata", WData, 8'h04);
        check("w0_end_count", count, 4);

        // Single W1 write, then a single read to park the pointer at W0.
        tick();
        w1_req  = 1'b1;
        w1_data = 8'h05;
        #1;
        check("w1_single_gnt", w1_gnt, 1);
        check("w1_single_w0gnt", w0_gnt, 0);
        tick();
        w1_req = 1'b0;
        #1;
        check("w1_single_count", count, 5);
        r_req = 1'b1;
        #1;
        check("rd_single_gnt", r_gnt, 1);
        tick();
        r_req = 1'b0;
        #1;
        check("rd_single_mode", mode, 2'b01);
        check("rd_single_count", count, 4);
        tick();
        check("rd_single_valid", r_valid, 1);
        check("rd_single_data", r_data, 8'h01);
        tick();
        check("rd_single_valid_drop", r_valid, 0);

        // All three requesting at count=4 with the pointer at W0.
        w0_req  = 1'b1;
        w1_req  = 1'b1;
        r_req   = 1'b1;
        w0_data = 8'h11;
        w1_data = 8'h21;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr3_gnt", {r_gnt, w1_gnt, w0_gnt}, exp_g[i]);
            if (i > 0) check("rr3_count", count, exp_c[i-1]);
            if (i == 4) begin
                check("rr3_valid", r_valid, 1);
                check("rr3_rdata", r_data, 8'h02);
            end
            tick();
        end
        w0_req = 1'b0;
        w1_req = 1'b0;
        r_req  = 1'b0;
        #1;
        check("rr3_final_count", count, 6);
        tick();
        check("rr3_valid2", r_valid, 1);
        check("rr3_rdata2", r_data, 8'h03);

        // Drain to empty, then a read request at count=0 is refused.
        r_req = 1'b1;
        for (int j = 0; j < 7; j++) begin
            #1;
            check("drain_gnt", r_gnt, (j < 6) ? 1 : 0);
            if (j == 2) check("drain_rdata", r_data, 8'h04);
            if (j == 6) check("drain_count", count, 0);
            tick();
        end
        r_req = 1'b0;
        #1;
        check("empty_mode", mode, 2'b00);
        check("empty_err", err, 0);
        tick();
        tick();

        // Both producers from empty: alternate until full.
        w0_req = 1'b1;
        w1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w0_data = 8'(i + 1);
            w1_data = 8'(i + 1);
            #1;
            check("fill_w0_gnt", w0_gnt, (i % 2 == 0) ? 1 : 0);
            check("fill_w1_gnt", w1_gnt, (i % 2 == 1) ? 1 : 0);
            if (i > 0) check("fill_wdata", WData, i);
            tick();
        end
        #1;
        check("full_w0_gnt", w0_gnt, 0);
        check("full_w1_gnt", w1_gnt, 0);
        check("full_count", count, 8);
        check("full_wdata", WData, 8'h08);
        tick();
        check("full_mode_idle", mode, 2'b00);
        w0_req = 1'b0;
        w1_req = 1'b0;

        // Single read at count=8 returns the oldest entry.
        r_req = 1'b1;
        #1;
        check("full_rd_gnt", r_gnt, 1);
        tick();
        r_req = 1'b0;
        #1;
        check("full_rd_mode", mode, 2'b01);
        check("full_rd_count", count, 7);
        check("full_rd_valid_early", r_valid, 0);
        tick();
        check("full_rd_valid", r_valid, 1);
        check("full_rd_data", r_data, 8'h01);
        tick();
        check("full_rd_valid_drop", r_valid, 0);

        // Write command while the buffer claims full sets the sticky error.
        w0_req  = 1'b1;
        w0_data = 8'hAA;
        #1;
        check("err_wr_gnt", w0_gnt, 1);
        tick();
        w0_req     = 1'b0;
        force_full = 1'b1;
        #1;
        check("err_wr_mode", mode, 2'b10);
        check("err_before", err, 0);
        tick();
        force_full = 1'b0;
        #1;
        check("err_set", err, 1);
        check("err_count", count, 8);
        tick();
        tick();
        check("err_sticky", err, 1);

        // Reset the cycle after a read grant: the read must never complete.
        r_req = 1'b1;
        #1;
        check("rst_rd_gnt", r_gnt, 1);
        tick();
        r_req = 1'b0;
        #1;
        check("rst_rd_mode_pre", mode, 2'b01);
        reset_n = 1'b0;
        #1;
        check("rst_async_mode", mode, 2'b00);
        check("rst_async_count", count, 0);
        check("rst_async_err", err, 0);
        check("rst_async_valid", r_valid, 0);
        tick();
        check("rst_hold_valid", r_valid, 0);
        reset_n = 1'b1;
        tick();
        check("rst_after_valid", r_valid, 0);
        check("rst_after_count", count, 0);
        check("rst_after_mode", mode, 2'b00);
        tick();
        check("rst_after_valid2", r_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_buffer_arbiter.md
RING_BUFFER_ARBITER -- requirements
Module: ring_buffer_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, the data width in bits.
REQ-002 SHALL have parameter PTR_SIZE, default 3, the buffer pointer width; capacity DEPTH = 2**PTR_SIZE entries.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports w0_req, w1_req  input  1  write requests from producers 0 and 1.
REQ-006 SHALL have ports w0_data, w1_data  input  REG_WIDTH  write data from producers 0 and 1.
REQ-007 SHALL have ports w0_gnt, w1_gnt  output  1  write grants; data is accepted on the edge that ends a grant cycle.
REQ-008 SHALL have port r_req  input  1  read request from the consumer.
REQ-009 SHALL have port r_gnt  output  1  read grant.
REQ-010 SHALL have ports r_valid  output  1 and r_data  output  REG_WIDTH  returned read data.
REQ-011 SHALL have port mode  output  2  buffer command: 00 idle, 01 read, 10 write; 11 is never driven.
REQ-012 SHALL have port WData  output  REG_WIDTH  write data to the buffer.
REQ-013 SHALL have port RData  input  REG_WIDTH  read data from the buffer.
REQ-014 SHALL have ports isEmpty, isFull  input  1  buffer status flags.
REQ-015 SHALL have port count  output  PTR_SIZE+1  controller-tracked occupancy, 0..DEPTH.
REQ-016 SHALL have port err  output  1  sticky buffer/controller consistency error.

Function
REQ-017 SHALL treat W0 and W1 as eligible only when count < DEPTH, and R as eligible only when count > 0; isFull/isEmpty SHALL NOT gate eligibility.
REQ-018 SHALL grant at most one requester per cycle, with grants combinational from the current-cycle requests, count and priority pointer.
REQ-019 SHALL arbitrate round-robin over the order W0, W1, R: search starts at the pointer, the first eligible requesting slot wins, and the pointer moves to the slot after the winner; the pointer is unchanged when nothing is granted.
REQ-020 SHALL register mode and WData on the grant edge: a write grant in cycle N gives mode=10 with the granted producer's data in cycle N+1; a read grant gives mode=01 in N+1; no grant gives mode=00 in N+1.
REQ-021 SHALL update count on the grant edge: +1 for a write grant, -1 for a read grant, and no change otherwise; it never wraps.
REQ-022 SHALL assert r_valid for exactly one cycle, N+2, after a read grant in cycle N, with r_data equal to RData in that same cycle.
REQ-023 SHALL set err on the edge ending any cycle where mode=10 and isFull=1, or mode=01 and isEmpty=1; once set, err SHALL stay high until reset.
REQ-024 SHALL support back-to-back grants every cycle with no bubble, including a write immediately followed by a read of the same entry.

Reset
REQ-025 SHALL, while reset_n=0, immediately force mode=00, WData=0, count=0, r_valid=0, err=0, and the pointer to W0; grants SHALL be 0.
REQ-026 SHALL drop any in-flight command on reset: a read granted before reset SHALL never produce r_valid.
REQ-027 SHALL grant on the first clock edge after reset_n rises if a request is eligible.

Verification
REQ-028 SHALL pass: after reset, w0_req held for 4 cycles with w0_data 01,02,03,04 -> w0_gnt high for 4 cycles; mode=10 with WData 01..04 one cycle later each; count=4.
REQ-029 SHALL pass: w0_req and w1_req held continuously from empty -> grants alternate W0,W1,W0...; after 8 grants count=8, both grants low, mode=00 thereafter.
REQ-030 SHALL pass: at count=8 with the buffer holding 01..08, r_req pulsed for 1 cycle -> r_gnt in N, mode=01 in N+1, r_valid with r_data=01 in N+2; count=7.
REQ-031 SHALL pass: all three requesting at count=4 with the pointer at W0 -> grant order W0,W1,R,W0,W1,R; count goes 5,6,5,6,7,6.
REQ-032 SHALL pass: r_req at count=0 -> no r_gnt, mode=00, err=0; then a stub drives isFull=1 during a mode=10 cycle -> err=1 on the next edge and stays 1 until reset_n=0.
REQ-033 SHALL pass: reset_n pulled low the cycle after r_gnt -> mode=00 at once, r_valid never asserts, count=0 after release.
